mem_access_unit: RTL and testbench

Memory-stage access controller for the pipelined LC-3b datapath. It sits directly downstream of the EX/MEM pipeline buffer and consumes its control bits, MAR and MDR outputs. It sequences one or two data-memory transactions per instruction: one for LDR/STR/LDB/STB, two for LDI/STI. While an access is outstanding it holds `stall_out` high so that upstream buffers keep their `load` low.

---
 rtl/mem_access_unit.sv | 97 +++++++++
 tb/tb_mem_access_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: LC-3b memory-stage access FSM; optional response watchdog via MEM_TIMEOUT_EN
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        indirect_in,
  input  logic        byte_in,
  input  logic [15:0] mar_in,
  input  logic [15:0] mdr_in,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        dmem_read,
  output logic        dmem_write,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall_out,
  output logic        done_out,
  output logic [15:0] mem_data_out,
  output logic        error_out
);
  localparam logic [1:0] IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [15:0] addr_q, mdr_q, ptr_q, data_q, data_d, ea;
  logic [7:0] lb;
  logic wr_q, ind_q, byte_q, err_q, err_d;
  logic req, s1, s2, acc, hit, ldc, word, tmo;
  assign req = valid_in & (mem_read_in | mem_write_in);
  assign s1 = state_q == ACC1;
  assign s2 = state_q == ACC2;
  assign acc = s1 | s2;
  assign hit = acc & dmem_resp;
  assign ldc = hit & ~wr_q & ((s1 & ~ind_q) | s2);
  assign lb = addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign tmo = acc & ~dmem_resp & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset || !acc || hit) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q == IDLE ? (req ? ACC1 : IDLE) :
              state_q == DONE ? IDLE :
              tmo ? DONE :
              !dmem_resp ? state_q :
              (s1 & ind_q) ? ACC2 : DONE;
    err_d = tmo;
    data_d = !ldc ? data_q : byte_q ? {8'h00, lb} : dmem_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      mdr_q <= '0;
      ptr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      ind_q <= 1'b0;
      byte_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      err_q <= err_d;
      if (state_q == IDLE && req) begin
        addr_q <= mar_in;
        mdr_q <= mdr_in;
        wr_q <= mem_write_in;
        ind_q <= indirect_in;
        byte_q <= byte_in & ~indirect_in;
      end
      if (s1 && hit && ind_q) ptr_q <= dmem_rdata;
    end
  end
  assign word = s2 | ~byte_q;
  assign ea = s2 ? ptr_q : addr_q;
  assign dmem_read = acc & ~wr_q | s1 & ind_q;
  assign dmem_write = acc & wr_q & (s2 | ~ind_q);
  assign dmem_address = !acc ? '0 : word ? {ea[15:1], 1'b0} : ea;
  assign dmem_byte_enable = !acc ? 2'b00 : word ? 2'b11 : addr_q[0] ? 2'b10 : 2'b01;
  assign dmem_wdata = !dmem_write ? '0 : byte_q ? {mdr_q[7:0], mdr_q[7:0]} : mdr_q;
  assign stall_out = (state_q == IDLE & req) | acc;
  assign done_out = state_q == DONE;
  assign mem_data_out = data_q;
  assign error_out = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a scripted memory responder
module tb_mem_access_unit;
  logic clk, reset, valid_in, mem_read_in, mem_write_in, indirect_in, byte_in;
  logic [15:0] mar_in, mdr_in, dmem_address, dmem_wdata, dmem_rdata, mem_data_out;
  logic [1:0] dmem_byte_enable;
  logic dmem_read, dmem_write, dmem_resp, stall_out, done_out, error_out;
  logic force_resp;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] addr;
    logic [1:0] be;
    logic wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int wt;
  } acc_t;
  acc_t acc_q[$];
  logic [16:0] sb_q[$];
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .indirect_in(indirect_in), .byte_in(byte_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .stall_out(stall_out),
    .done_out(done_out), .mem_data_out(mem_data_out), .error_out(error_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic exp_acc(input logic [15:0] addr, input logic [1:0] be, input logic wr,
                         input logic [15:0] wdata, input logic [15:0] rdata, input int wt);
    acc_t a;
    a.addr = addr; a.be = be; a.wr = wr; a.wdata = wdata; a.rdata = rdata; a.wt = wt;
    acc_q.push_back(a);
  endtask
  task automatic issue(input logic rd, input logic wr, input logic ind, input logic byt,
                       input logic [15:0] mar, input logic [15:0] mdr,
                       input logic [15:0] exp_data, input logic exp_err, input int exp_stall);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    sb_q.push_back({exp_err, exp_data});
    @(posedge clk); #1;
    valid_in = 1; mem_read_in = rd; mem_write_in = wr; indirect_in = ind; byte_in = byt;
    mar_in = mar; mdr_in = mdr;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (stall_out) n++;
      if (done_out) seen = 1;
    end
    valid_in = 0; mem_read_in = 0; mem_write_in = 0; indirect_in = 0; byte_in = 0;
    check("done_seen", seen, 1);
    check("stall_cycles", n, exp_stall);
    @(negedge clk);
    check("idle_after_done", {done_out, stall_out}, 0);
  endtask
  initial begin
    bit fresh;
    int waited;
    acc_t cur;
    fresh = 1;
    waited = 0;
    dmem_resp = 0;
    dmem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      dmem_resp = force_resp;
      dmem_rdata = 16'hDEAD;
      if (dmem_read === 1'b1 || dmem_write === 1'b1) begin
        if (fresh) begin
          check("access_expected", acc_q.size() != 0, 1);
          if (acc_q.size() != 0) cur = acc_q.pop_front();
          fresh = 0;
          waited = 0;
        end
        check("acc_addr", dmem_address, cur.addr);
        check("acc_be", dmem_byte_enable, cur.be);
        check("acc_rw", {dmem_write, dmem_read}, cur.wr ? 2'b10 : 2'b01);
        if (cur.wr) check("acc_wdata", dmem_wdata, cur.wdata);
        if (waited == cur.wt) begin
          dmem_resp = 1;
          dmem_rdata = cur.rdata;
          fresh = 1;
        end else waited++;
      end else fresh = 1;
    end
  end
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (done_out === 1'b1) begin
        check("done_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("mem_data_out", mem_data_out, e[15:0]);
          check("error_out", error_out, e[16]);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1; valid_in = 0; mem_read_in = 0; mem_write_in = 0; indirect_in = 0; byte_in = 0;
    mar_in = 0; mdr_in = 0; force_resp = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_outputs", {dmem_address, dmem_wdata, dmem_byte_enable, dmem_read, dmem_write,
                            stall_out, done_out, mem_data_out, error_out}, 0);
    @(posedge clk); #1;
    valid_in = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonmem_no_stall", {stall_out, done_out}, 0);
    end
    valid_in = 0; mem_read_in = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bubble_no_stall", {stall_out, done_out}, 0);
    end
    mem_read_in = 0;
    exp_acc(16'h3000, 2'b11, 0, 0, 16'hBEEF, 1);
    issue(1, 0, 0, 0, 16'h3001, 16'h0000, 16'hBEEF, 0, 3);
    exp_acc(16'h4005, 2'b10, 1, 16'hABAB, 0, 0);
    issue(0, 1, 0, 1, 16'h4005, 16'h12AB, 16'hBEEF, 0, 2);
    exp_acc(16'h4004, 2'b01, 0, 0, 16'h80F0, 0);
    issue(1, 0, 0, 1, 16'h4004, 16'h0000, 16'h00F0, 0, 2);
    exp_acc(16'h4007, 2'b10, 0, 0, 16'h80F0, 0);
    issue(1, 0, 0, 1, 16'h4007, 16'h0000, 16'h0080, 0, 2);
    exp_acc(16'h2002, 2'b11, 1, 16'hCAFE, 0, 0);
    issue(1, 1, 0, 0, 16'h2003, 16'hCAFE, 16'h0080, 0, 2);
    exp_acc(16'h5000, 2'b11, 0, 0, 16'h6002, 0);
    exp_acc(16'h6002, 2'b11, 0, 0, 16'h1234, 0);
    issue(1, 0, 1, 0, 16'h5000, 16'h0000, 16'h1234, 0, 3);
    exp_acc(16'h5000, 2'b11, 0, 0, 16'h6002, 1);
    exp_acc(16'h6002, 2'b11, 1, 16'h5555, 0, 0);
    issue(0, 1, 1, 1, 16'h5000, 16'h5555, 16'h1234, 0, 4);
    exp_acc(16'h7000, 2'b11, 0, 0, 16'h7777, 1000);
    @(posedge clk); #1;
    valid_in = 1; mem_read_in = 1; mar_in = 16'h7000;
    @(negedge clk);
    check("rst_test_detect_stall", stall_out, 1);
    @(negedge clk);
    check("rst_test_acc1_read", {stall_out, dmem_read}, 2'b11);
    @(posedge clk); #1;
    reset = 1; valid_in = 0; mem_read_in = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("midreset_outputs", {dmem_address, dmem_wdata, dmem_byte_enable, dmem_read, dmem_write,
                               stall_out, done_out, mem_data_out, error_out}, 0);
    @(posedge clk); #1;
    force_resp = 1;
    @(posedge clk); #1;
    force_resp = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("late_resp_ignored", {stall_out, done_out, dmem_read, dmem_write, mem_data_out}, 0);
    end
    exp_acc(16'h3000, 2'b11, 0, 0, 16'hBEEF, 0);
    issue(1, 0, 0, 0, 16'h3001, 16'h0000, 16'hBEEF, 0, 2);
`ifdef MEM_TIMEOUT_EN
    exp_acc(16'h3000, 2'b11, 0, 0, 16'h1111, 1000);
    issue(1, 0, 0, 0, 16'h3000, 16'h0000, 16'hBEEF, 1, 5);
    exp_acc(16'h4004, 2'b01, 0, 0, 16'h0042, 0);
    issue(1, 0, 0, 1, 16'h4004, 16'h0000, 16'h0042, 0, 2);
`endif
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("accesses_drained", acc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
